// File: rtl/jedro_1_decoder_if.sv
// jedro_1_decoder_if: instruction-in / decoded-out handshake bundle of the decode stage
interface jedro_1_decoder_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   instr_i;
  logic                    instr_valid_i;
  logic                    instr_ready_o;
  logic                    dec_valid_o;
  logic                    dec_ready_i;
  logic [ALU_OP_WIDTH-1:0] alu_op_sel_o;
  logic [4:0]              rs1_addr_o;
  logic [4:0]              rs2_addr_o;
  logic [4:0]              rd_addr_o;
  logic                    rd_we_o;
  logic [DATA_WIDTH-1:0]   imm_o;
  logic                    use_imm_o;
  logic                    illegal_instr_o;
  logic                    illegal_ack_i;
  modport master (
    output instr_i, instr_valid_i, dec_ready_i, illegal_ack_i,
    input  instr_ready_o, dec_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o
  );
  modport slave (
    input  instr_i, instr_valid_i, dec_ready_i, illegal_ack_i,
    output instr_ready_o, dec_valid_o, alu_op_sel_o, rs1_addr_o, rs2_addr_o,
           rd_addr_o, rd_we_o, imm_o, use_imm_o, illegal_instr_o
  );
endinterface

// File: rtl/jedro_1_decoder.sv
// jedro_1_decoder: RV32I OP/OP-IMM/LUI decode stage with sticky illegal-instruction trap
module jedro_1_decoder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input logic             clk_i,
  input logic             rstn_i,
  jedro_1_decoder_if.slave bus
);
  typedef enum logic {RUN, ILLEGAL} state_t;
  state_t state;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_op, is_opi, is_lui, legal, shift, accept;
  logic [ALU_OP_WIDTH-1:0] op;
  logic [4:0] rs1, rs2;
  logic [DATA_WIDTH-1:0] imm;
  // field extraction and legality of the incoming word
  always_comb begin
    opc    = bus.instr_i[6:0];
    f3     = bus.instr_i[14:12];
    f7     = bus.instr_i[31:25];
    is_op  = opc == 7'b0110011;
    is_opi = opc == 7'b0010011;
    is_lui = opc == 7'b0110111;
    shift  = f3[1:0] == 2'b01;
    legal  = (is_op & ((f7 == 7'h00) | ((f7 == 7'h20) & ((f3 == 3'b000) | (f3 == 3'b101)))))
           | (is_opi & ((f3 == 3'b001) ? (f7 == 7'h00) : (f3 == 3'b101) ? ((f7 == 7'h00) | (f7 == 7'h20)) : 1'b1))
           | is_lui;
    op     = is_op ? {bus.instr_i[30], f3} : is_opi ? {(f3 == 3'b101) & bus.instr_i[30], f3} : '0;
    rs1    = is_lui ? 5'd0 : bus.instr_i[19:15];
    rs2    = is_op ? bus.instr_i[24:20] : 5'd0;
    imm    = is_lui ? {bus.instr_i[31:12], 12'b0}
           : (is_opi & shift) ? {27'b0, bus.instr_i[24:20]}
           : is_opi ? {{20{bus.instr_i[31]}}, bus.instr_i[31:20]} : '0;
  end
  assign bus.instr_ready_o   = (state == RUN) & (~bus.dec_valid_o | bus.dec_ready_i);
  assign bus.illegal_instr_o = state == ILLEGAL;
  assign accept              = bus.instr_valid_i & bus.instr_ready_o;
  // pipeline register and RUN/ILLEGAL control; an illegal word is swallowed, never forwarded
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= RUN;
      bus.dec_valid_o  <= 1'b0;
      bus.alu_op_sel_o <= '0;
      bus.rs1_addr_o   <= '0;
      bus.rs2_addr_o   <= '0;
      bus.rd_addr_o    <= '0;
      bus.rd_we_o      <= 1'b0;
      bus.imm_o        <= '0;
      bus.use_imm_o    <= 1'b0;
    end else if (state == ILLEGAL) begin
      state <= bus.illegal_ack_i ? RUN : ILLEGAL;
    end else if (accept & legal) begin
      bus.dec_valid_o  <= 1'b1;
      bus.alu_op_sel_o <= op;
      bus.rs1_addr_o   <= rs1;
      bus.rs2_addr_o   <= rs2;
      bus.rd_addr_o    <= bus.instr_i[11:7];
      bus.rd_we_o      <= bus.instr_i[11:7] != 5'd0;
      bus.imm_o        <= imm;
      bus.use_imm_o    <= ~is_op;
    end else if (accept) begin
      state           <= ILLEGAL;
      bus.dec_valid_o <= 1'b0;
    end else if (bus.dec_ready_i) begin
      bus.dec_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jedro_1_decoder.sv
// tb_jedro_1_decoder: directed self-checking bench for the decode stage
module tb_jedro_1_decoder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  jedro_1_decoder_if bus ();
  jedro_1_decoder dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
  always #5 clk = ~clk;
  logic [53:0] obs;
  assign obs = {bus.dec_valid_o, bus.alu_op_sel_o, bus.rs1_addr_o, bus.rs2_addr_o,
                bus.rd_addr_o, bus.rd_we_o, bus.use_imm_o, bus.imm_o};
  // {valid, op, rs1, rs2, rd, rd_we, use_imm, imm}
  localparam logic [53:0] E_ADD  = {1'b1, 4'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0};
  localparam logic [53:0] E_SUB  = {1'b1, 4'h8, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0};
  localparam logic [53:0] E_SRA  = {1'b1, 4'hD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0};
  localparam logic [53:0] E_SRAI = {1'b1, 4'hD, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 32'h3};
  localparam logic [53:0] E_ADDI = {1'b1, 4'h0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'hFFFFFFFF};
  localparam logic [53:0] E_LUI  = {1'b1, 4'h0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h12345000};
  localparam logic [53:0] E_ADD0 = {1'b1, 4'h0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0};
  localparam logic [53:0] E_ORI  = {1'b1, 4'h6, 5'd2, 5'd0, 5'd4, 1'b1, 1'b1, 32'h7FF};
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_LUI  = 32'h123453B7;
  localparam logic [31:0] I_ADD0 = 32'h00208033;
  localparam logic [31:0] I_ORI  = 32'h7FF16213;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_BADF = 32'h022081B3;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 54'h0 || bus.illegal_instr_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %h ill=%b exp 0 ill=0", obs, bus.illegal_instr_o);
    end
    step();
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b exp 1", bus.instr_ready_o);
    end
  endtask

  task automatic test_single(input string name, input logic [31:0] ins, input logic [53:0] exp);
    bus.instr_i = ins;
    bus.instr_valid_i = 1'b1;
    bus.dec_ready_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h exp %h", name, obs, exp);
    end
    step();
    checks++;
    if (bus.dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: dec_valid got %b exp 0", name, bus.dec_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.dec_ready_i = 1'b1;
    bus.instr_i = I_ADD;
    bus.instr_valid_i = 1'b1;
    step();
    checks++;
    if (obs !== E_ADD || bus.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got %h rdy=%b exp %h rdy=1", obs, bus.instr_ready_o, E_ADD);
    end
    bus.instr_i = I_SUB;
    step();
    bus.dec_ready_i = 1'b0;
    bus.instr_i = I_ADDI;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== E_SUB || bus.instr_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stall%0d: got %h rdy=%b exp %h rdy=0", i, obs, bus.instr_ready_o, E_SUB);
      end
      step();
    end
    bus.dec_ready_i = 1'b1;
    #1;
    checks++;
    if (obs !== E_SUB || bus.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_release: got %h rdy=%b exp %h rdy=1", obs, bus.instr_ready_o, E_SUB);
    end
    step();
    checks++;
    if (obs !== E_ADDI) begin
      failures++;
      $display("FAIL b2b_third: got %h exp %h", obs, E_ADDI);
    end
    bus.instr_i = I_LUI;
    step();
    bus.instr_valid_i = 1'b0;
    checks++;
    if (obs !== E_LUI) begin
      failures++;
      $display("FAIL b2b_fourth: got %h exp %h", obs, E_LUI);
    end
    step();
    checks++;
    if (bus.dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_dup: dec_valid got %b exp 0", bus.dec_valid_o);
    end
  endtask

  task automatic test_illegal(input string name, input logic [31:0] ins, input logic pend);
    bus.dec_ready_i = 1'b1;
    if (pend) begin
      bus.instr_i = I_ADD;
      bus.instr_valid_i = 1'b1;
      step();
    end
    bus.instr_i = ins;
    bus.instr_valid_i = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.illegal_instr_o !== 1'b1 || bus.instr_ready_o !== 1'b0 || bus.dec_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_trap%0d: ill=%b rdy=%b vld=%b exp 1 0 0", name, i,
                 bus.illegal_instr_o, bus.instr_ready_o, bus.dec_valid_o);
      end
      bus.instr_i = I_ADD;
      step();
    end
    bus.instr_valid_i = 1'b0;
    bus.illegal_ack_i = 1'b1;
    step();
    bus.illegal_ack_i = 1'b0;
    checks++;
    if (bus.illegal_instr_o !== 1'b0 || bus.instr_ready_o !== 1'b1 || bus.dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack: ill=%b rdy=%b vld=%b exp 0 1 0", name,
               bus.illegal_instr_o, bus.instr_ready_o, bus.dec_valid_o);
    end
    test_single({name, "_after"}, I_ADD, E_ADD);
  endtask

  task automatic test_ack_in_run();
    bus.illegal_ack_i = 1'b1;
    step();
    bus.illegal_ack_i = 1'b0;
    checks++;
    if (bus.illegal_instr_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ack_in_run: ill=%b rdy=%b exp 0 1", bus.illegal_instr_o, bus.instr_ready_o);
    end
  endtask

  task automatic test_async_reset();
    bus.instr_i = I_SUB;
    bus.instr_valid_i = 1'b1;
    bus.dec_ready_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    bus.dec_ready_i = 1'b0;
    step();
    checks++;
    if (obs !== E_SUB || bus.instr_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_prestall: got %h rdy=%b exp %h rdy=0", obs, bus.instr_ready_o, E_SUB);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 54'h0 || bus.illegal_instr_o !== 1'b0 || bus.instr_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_async: got %h ill=%b rdy=%b exp 0 0 1", obs, bus.illegal_instr_o, bus.instr_ready_o);
    end
    step();
    rstn = 1'b1;
    step();
    checks++;
    if (bus.instr_ready_o !== 1'b1 || bus.dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: rdy=%b vld=%b exp 1 0", bus.instr_ready_o, bus.dec_valid_o);
    end
  endtask

  initial begin
    bus.instr_i = '0;
    bus.instr_valid_i = 1'b0;
    bus.dec_ready_i = 1'b0;
    bus.illegal_ack_i = 1'b0;
    test_reset();
    step();
    test_single("add", I_ADD, E_ADD);
    test_single("sub", I_SUB, E_SUB);
    test_single("sra", I_SRA, E_SRA);
    test_single("srai", I_SRAI, E_SRAI);
    test_single("addi", I_ADDI, E_ADDI);
    test_single("ori", I_ORI, E_ORI);
    test_single("lui", I_LUI, E_LUI);
    test_single("add_x0", I_ADD0, E_ADD0);
    test_back_to_back();
    test_illegal("jal", I_JAL, 1'b1);
    test_illegal("bad_funct7", I_BADF, 1'b0);
    test_ack_in_run();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
